// File: rtl/sprite_line_renderer_pkg.sv
// Shared widths, state encodings and the attribute record for the scanline sprite renderer.
package sprite_line_renderer_pkg;

  localparam int ATTR_X_W    = 10;
  localparam int ATTR_Y_W    = 10;
  localparam int ATTR_NUM_W  = 6;
  localparam int ATTR_W      = ATTR_X_W + ATTR_Y_W + ATTR_NUM_W + 1;
  localparam int LB_BANK_SIZE = 256;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [ATTR_X_W-1:0]   x;
    logic [ATTR_Y_W-1:0]   y;
    logic [ATTR_NUM_W-1:0] num;
    logic                  en;
  } attr_t;

  // Line-buffer x for a sprite column: half-resolution X plus column, kept 10 bits for clipping.
  function automatic logic [9:0] line_x(input logic [8:0] x_half, input logic [2:0] col);
    return {1'b0, x_half} + {7'b0, col};
  endfunction

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Attribute, sprite ROM and line RAM signals of the sprite renderer; slave is the renderer side.
interface sprite_line_renderer_if #(parameter int NUM_SPRITES = 8);
  import sprite_line_renderer_pkg::*;

  localparam int SEL_W = $clog2(NUM_SPRITES);

  logic                  i_Line_Start;
  logic [9:0]            i_Next_Row;
  logic                  i_Attr_Wr;
  logic [SEL_W-1:0]      i_Attr_Sel;
  logic [ATTR_X_W-1:0]   i_Attr_X;
  logic [ATTR_Y_W-1:0]   i_Attr_Y;
  logic [ATTR_NUM_W-1:0] i_Attr_Num;
  logic                  i_Attr_En;
  logic [5:0]            o_Rom_Sprite;
  logic [2:0]            o_Rom_Row;
  logic [2:0]            o_Rom_Col;
  logic [1:0]            i_Rom_Pixel;
  logic                  o_Lr_Write;
  logic [10:0]           o_Lr_Addr;
  logic [1:0]            o_Lr_Data;
  logic                  o_Busy;
  logic                  o_Overrun;

  modport slave (
    input  i_Line_Start, i_Next_Row, i_Attr_Wr, i_Attr_Sel, i_Attr_X, i_Attr_Y,
           i_Attr_Num, i_Attr_En, i_Rom_Pixel,
    output o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_Write, o_Lr_Addr, o_Lr_Data,
           o_Busy, o_Overrun
  );

  modport master (
    output i_Line_Start, i_Next_Row, i_Attr_Wr, i_Attr_Sel, i_Attr_X, i_Attr_Y,
           i_Attr_Num, i_Attr_En, i_Rom_Pixel,
    input  o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_Write, o_Lr_Addr, o_Lr_Data,
           o_Busy, o_Overrun
  );

endinterface

// File: rtl/sprite_line_renderer_attr_table.sv
// Sprite attribute register file: one synchronous write port, one combinational read port.
module sprite_attr_table
  import sprite_line_renderer_pkg::*;
#(
  parameter  int NUM_SPRITES = 8,
  localparam int SEL_W       = $clog2(NUM_SPRITES)
) (
  input  logic             i_Clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  attr_t            wr_data,
  input  logic [SEL_W-1:0] rd_sel,
  output attr_t            rd_data
);

  attr_t table_q [NUM_SPRITES];

  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_sel] <= wr_data;
    end
  end

  assign rd_data = table_q[rd_sel];

endmodule

// File: rtl/sprite_line_renderer.sv
// Scanline sprite renderer: clears the next row's line-RAM bank, then draws every sprite hitting it.
//
// state | meaning
// IDLE  | waiting for a line start
// CLEAR | writing 0 over the 256 entries of the target bank
// SCAN  | testing attribute entry idx against the row
// FETCH | issuing 8 ROM columns plus one drain cycle
// DONE  | one cycle of wrap-up before IDLE
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter int NUM_SPRITES = 8
) (
  input  logic                   i_Clk,
  input  logic                   reset,
  sprite_line_renderer_if.slave  bus
);

  localparam int               SEL_W    = $clog2(NUM_SPRITES);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_SPRITES - 1);

  logic [2:0]       state;
  logic [9:0]       row;
  logic             bank;
  logic [7:0]       clr_addr;
  logic [SEL_W-1:0] idx;
  logic [3:0]       fcnt;
  logic [5:0]       cur_num;
  logic [2:0]       cur_row;
  logic [8:0]       cur_xh;
  logic             pend;
  logic [9:0]       pend_hx;
  logic             lr_write;
  logic [10:0]      lr_addr;
  logic [1:0]       lr_data;
  logic             overrun;

  attr_t      entry;
  attr_t      wr_data;
  logic [9:0] dy;
  logic       hit;
  logic       busy;
  logic       pix_wr;
  logic       unused_bits;

  assign wr_data = {bus.i_Attr_X, bus.i_Attr_Y, bus.i_Attr_Num, bus.i_Attr_En};

  sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_attr (
    .i_Clk   (i_Clk),
    .reset   (reset),
    .wr_en   (bus.i_Attr_Wr),
    .wr_sel  (bus.i_Attr_Sel),
    .wr_data (wr_data),
    .rd_sel  (idx),
    .rd_data (entry)
  );

  assign dy     = row - entry.y;
  assign hit    = entry.en && (dy < 10'd16);
  assign busy   = (state != ST_IDLE) || pend;
  assign pix_wr = pend && (bus.i_Rom_Pixel != 2'b00) && (pend_hx < 10'(LB_BANK_SIZE));

  // X[0] is dropped by the 2-pixel horizontal quantisation; dy[0] by the 2-row ROM rows.
  assign unused_bits = entry.x[0] ^ dy[0];

  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      bank     <= 1'b0;
      clr_addr <= '0;
      idx      <= '0;
      fcnt     <= '0;
      cur_num  <= '0;
      cur_row  <= '0;
      cur_xh   <= '0;
      pend     <= 1'b0;
      pend_hx  <= '0;
      lr_write <= 1'b0;
      lr_addr  <= '0;
      lr_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      lr_write <= 1'b0;
      if (bus.i_Line_Start) begin
        // A restart drops the in-flight pixel and issues the first clear write straight away.
        overrun  <= busy;
        row      <= bus.i_Next_Row;
        bank     <= bus.i_Next_Row[1];
        state    <= ST_CLEAR;
        clr_addr <= '0;
        pend     <= 1'b0;
        lr_write <= 1'b1;
        lr_addr  <= {2'b00, bus.i_Next_Row[1], 8'd0};
        lr_data  <= 2'b00;
      end else begin
        pend <= 1'b0;
        if (pix_wr) begin
          lr_write <= 1'b1;
          lr_addr  <= {2'b00, bank, pend_hx[7:0]};
          lr_data  <= bus.i_Rom_Pixel;
        end
        case (state)
          ST_CLEAR: begin
            if (clr_addr == 8'(LB_BANK_SIZE - 1)) begin
              state <= ST_SCAN;
              idx   <= IDX_LAST;
            end else begin
              clr_addr <= clr_addr + 8'd1;
              lr_write <= 1'b1;
              lr_addr  <= {2'b00, bank, clr_addr + 8'd1};
              lr_data  <= 2'b00;
            end
          end
          ST_SCAN: begin
            if (hit) begin
              state   <= ST_FETCH;
              fcnt    <= '0;
              cur_num <= entry.num;
              cur_row <= dy[3:1];
              cur_xh  <= entry.x[9:1];
            end else if (idx == '0) begin
              state <= ST_DONE;
            end else begin
              idx <= idx - 1'b1;
            end
          end
          ST_FETCH: begin
            if (fcnt != 4'd8) begin
              pend    <= 1'b1;
              pend_hx <= line_x(cur_xh, fcnt[2:0]);
              fcnt    <= fcnt + 4'd1;
            end else if (idx == '0) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= ST_SCAN;
            end
          end
          ST_DONE:  state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_Rom_Sprite = cur_num;
  assign bus.o_Rom_Row    = cur_row;
  assign bus.o_Rom_Col    = fcnt[2:0];
  assign bus.o_Lr_Write   = lr_write;
  assign bus.o_Lr_Addr    = lr_addr;
  assign bus.o_Lr_Data    = lr_data;
  assign bus.o_Busy       = busy;
  assign bus.o_Overrun    = overrun;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer with a behavioural one-cycle-latency sprite ROM.
module tb_sprite_line_renderer;

  logic i_Clk = 1'b0;
  logic reset = 1'b1;

  sprite_line_renderer_if #(.NUM_SPRITES(8)) bus ();

  sprite_line_renderer #(.NUM_SPRITES(8)) dut (
    .i_Clk (i_Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0] wq_addr [$];
  logic [1:0]  wq_data [$];
  int          wq_cyc  [$];

  // Sprite 1 is solid colour 1, sprite 2 solid colour 2, others a diagonal pattern.
  function automatic logic [1:0] rom_fn(input logic [5:0] num, input logic [2:0] r,
                                        input logic [2:0] c);
    logic [7:0] s;
    if (num == 6'd1) return 2'd1;
    if (num == 6'd2) return 2'd2;
    s = {2'b0, num} + {5'b0, r} + {5'b0, c};
    return s[1:0];
  endfunction

  always @(posedge i_Clk) bus.i_Rom_Pixel <= rom_fn(bus.o_Rom_Sprite, bus.o_Rom_Row, bus.o_Rom_Col);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_attr(input int sel, input logic [9:0] x, input logic [9:0] y,
                         input logic [5:0] num, input logic en);
    @(negedge i_Clk);
    bus.i_Attr_Sel = 3'(sel);
    bus.i_Attr_X   = x;
    bus.i_Attr_Y   = y;
    bus.i_Attr_Num = num;
    bus.i_Attr_En  = en;
    bus.i_Attr_Wr  = 1'b1;
    @(negedge i_Clk);
    bus.i_Attr_Wr  = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] r);
    @(negedge i_Clk);
    bus.i_Next_Row   = r;
    bus.i_Line_Start = 1'b1;
    @(posedge i_Clk);
    #1 bus.i_Line_Start = 1'b0;
  endtask

  task automatic collect(input int limit, output int idle_cyc);
    idle_cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge i_Clk);
      if (bus.o_Lr_Write) begin
        wq_addr.push_back(bus.o_Lr_Addr);
        wq_data.push_back(bus.o_Lr_Data);
        wq_cyc.push_back(n);
      end
      if (!bus.o_Busy) begin
        idle_cyc = n;
        break;
      end
    end
  endtask

  task automatic run_line(input logic [9:0] r, output int idle_cyc);
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    start_line(r);
    collect(600, idle_cyc);
  endtask

  task automatic check_clear(input string tag, input logic bank);
    int bad = 0;
    if (wq_addr.size() < 256) bad = 256;
    else begin
      for (int i = 0; i < 256; i++) begin
        if (wq_addr[i] !== {2'b00, bank, 8'(i)} || wq_data[i] !== 2'b00 || wq_cyc[i] != i + 1)
          bad++;
      end
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [10:0] a, input logic [1:0] d);
    logic [31:0] got;
    if (256 + i < wq_addr.size()) got = 32'({wq_addr[256 + i], wq_data[256 + i]});
    else got = 32'hdead;
    check(tag, got, 32'({a, d}));
  endtask

  initial begin
    int idle;
    int cnt;
    bus.i_Line_Start = 1'b0;
    bus.i_Next_Row   = '0;
    bus.i_Attr_Wr    = 1'b0;
    bus.i_Attr_Sel   = '0;
    bus.i_Attr_X     = '0;
    bus.i_Attr_Y     = '0;
    bus.i_Attr_Num   = '0;
    bus.i_Attr_En    = 1'b0;
    repeat (3) @(negedge i_Clk);
    reset = 1'b0;
    @(negedge i_Clk);

    check("rst_busy",    32'(bus.o_Busy),       32'd0);
    check("rst_write",   32'(bus.o_Lr_Write),   32'd0);
    check("rst_overrun", 32'(bus.o_Overrun),    32'd0);
    check("rst_addr",    32'(bus.o_Lr_Addr),    32'd0);
    check("rst_sprite",  32'(bus.o_Rom_Sprite), 32'd0);

    // Clear only, bank 0
    run_line(10'd5, idle);
    check("clr_count", 32'(wq_addr.size()), 32'd256);
    check_clear("clr_bank0", 1'b0);
    check("clr_idle", 32'(idle), 32'd266);

    // Bank select
    run_line(10'd2, idle);
    check("bank_count", 32'(wq_addr.size()), 32'd256);
    check_clear("bank1_clear", 1'b1);

    // Single hit: X=20 -> 0x00A.., dy=7 -> ROM row 3, columns 2 and 6 transparent
    wr_attr(0, 10'd20, 10'd6, 6'd3, 1'b1);
    run_line(10'd13, idle);
    check("hit_count", 32'(wq_addr.size()), 32'd262);
    check_clear("hit_clear", 1'b0);
    chk_wr("hit_w0", 0, 11'h00A, 2'd2);
    chk_wr("hit_w1", 1, 11'h00B, 2'd3);
    chk_wr("hit_w2", 2, 11'h00D, 2'd1);
    chk_wr("hit_w3", 3, 11'h00E, 2'd2);
    chk_wr("hit_w4", 4, 11'h00F, 2'd3);
    chk_wr("hit_w5", 5, 11'h011, 2'd1);
    check("hit_first_cyc", 32'(wq_cyc.size() > 256 ? wq_cyc[256] : -1), 32'd267);
    check("hit_idle", 32'(idle), 32'd275);

    // Priority: entry 1 (colour 1) drawn first, entry 0 (colour 2) last
    wr_attr(0, 10'd40, 10'd0, 6'd2, 1'b1);
    wr_attr(1, 10'd40, 10'd0, 6'd1, 1'b1);
    run_line(10'd0, idle);
    check("prio_count", 32'(wq_addr.size()), 32'd272);
    for (int i = 0; i < 16; i++)
      chk_wr($sformatf("prio_w%0d", i), i, 11'(20 + (i % 8)), (i < 8) ? 2'd1 : 2'd2);
    check("prio_idle", 32'(idle), 32'd284);

    // Clip: X=500 -> hx 250..257, only 250..255 written
    wr_attr(1, 10'd0, 10'd0, 6'd0, 1'b0);
    wr_attr(0, 10'd500, 10'd0, 6'd1, 1'b1);
    run_line(10'd0, idle);
    check("clip_count", 32'(wq_addr.size()), 32'd262);
    for (int i = 0; i < 6; i++)
      chk_wr($sformatf("clip_w%0d", i), i, 11'(250 + i), 2'd1);
    check("clip_idle", 32'(idle), 32'd275);

    // Miss at dy=16, hit at dy=15 (bank 1, ROM row 7)
    wr_attr(2, 10'd0, 10'd100, 6'd2, 1'b1);
    run_line(10'd116, idle);
    check("miss_count", 32'(wq_addr.size()), 32'd256);
    check("miss_idle", 32'(idle), 32'd266);
    run_line(10'd115, idle);
    check("dy15_count", 32'(wq_addr.size()), 32'd264);
    check_clear("dy15_clear", 1'b1);
    chk_wr("dy15_first", 0, 11'h100, 2'd2);
    chk_wr("dy15_last", 7, 11'h107, 2'd2);
    check("dy15_idle", 32'(idle), 32'd275);

    // Overrun: second line start during cycle 100
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    start_line(10'd5);
    repeat (100) @(negedge i_Clk);
    check("ovr_pre_busy", 32'(bus.o_Busy), 32'd1);
    check("ovr_pre_addr", 32'(bus.o_Lr_Addr), 32'd99);
    bus.i_Next_Row   = 10'd6;
    bus.i_Line_Start = 1'b1;
    @(posedge i_Clk);
    #1 bus.i_Line_Start = 1'b0;
    @(negedge i_Clk);
    check("ovr_pulse", 32'(bus.o_Overrun), 32'd1);
    check("ovr_restart", 32'({bus.o_Lr_Write, bus.o_Lr_Addr}), 32'({1'b1, 11'h100}));
    @(negedge i_Clk);
    check("ovr_pulse_end", 32'(bus.o_Overrun), 32'd0);
    check("ovr_addr1", 32'(bus.o_Lr_Addr), 32'h101);
    collect(600, idle);
    check("ovr_idle", 32'(idle), 32'd273);
    check("ovr_count", 32'(wq_addr.size()), 32'd260);

    // Reset during FETCH
    wr_attr(2, 10'd0, 10'd0, 6'd0, 1'b0);
    wr_attr(0, 10'd20, 10'd6, 6'd3, 1'b1);
    start_line(10'd13);
    repeat (268) @(negedge i_Clk);
    check("rstf_write_pre", 32'({bus.o_Lr_Write, bus.o_Lr_Addr, bus.o_Lr_Data}),
          32'({1'b1, 11'h00B, 2'd3}));
    reset = 1'b1;
    #1;
    check("rstf_write", 32'(bus.o_Lr_Write), 32'd0);
    check("rstf_busy",  32'(bus.o_Busy), 32'd0);
    @(negedge i_Clk);
    check("rstf_write_next", 32'(bus.o_Lr_Write), 32'd0);
    check("rstf_sprite", 32'(bus.o_Rom_Sprite), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge i_Clk);
      if (bus.o_Lr_Write || bus.o_Busy) cnt++;
    end
    check("rstf_quiet", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
